// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register Tnew countdowns and an optional HI/LO busy counter
// that generates D-stage stall requests. Define HAZARD_MDU_STALL_EN to enable HI/LO tracking.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned TNEW_W  = 2,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [$clog2(NREG)-1:0] d_rs,
  input  logic [$clog2(NREG)-1:0] d_rt,
  input  logic [TNEW_W-1:0]       d_tuse_rs,
  input  logic [TNEW_W-1:0]       d_tuse_rt,
  input  logic                    d_wr,
  input  logic [$clog2(NREG)-1:0] d_a3,
  input  logic [TNEW_W-1:0]       d_tnew,
  input  logic                    d_md_start,
  input  logic                    d_md_div,
  input  logic                    d_md_use,
  output logic                    stall,
  output logic                    stall_rs,
  output logic                    stall_rt,
  output logic                    stall_md,
  output logic                    md_busy
);

  logic [TNEW_W-1:0] cnt_q [NREG];
  logic [TNEW_W-1:0] cnt_d [NREG];
  logic              issue;

  // An all-ones Tuse can never be exceeded by a TNEW_W-bit count, so unused operands never stall.
  assign stall_rs = d_valid && (d_rs != '0) && (cnt_q[d_rs] > d_tuse_rs);
  assign stall_rt = d_valid && (d_rt != '0) && (cnt_q[d_rt] > d_tuse_rt);
  assign stall    = stall_rs | stall_rt | stall_md;
  assign issue    = d_valid && !stall;

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - TNEW_W'(1) : '0;
    end
    if (issue && d_wr && (d_a3 != '0)) begin
      cnt_d[d_a3] = d_tnew;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef HAZARD_MDU_STALL_EN
  localparam int unsigned MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned MDW    = $clog2(MD_MAX + 1);

  logic [MDW-1:0] mdc_q;
  logic [MDW-1:0] mdc_d;

  assign md_busy  = (mdc_q != '0);
  assign stall_md = d_valid && (d_md_use || d_md_start) && md_busy;

  always_comb begin
    mdc_d = mdc_q;
    if (issue && d_md_start) begin
      mdc_d = d_md_div ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
    end else if (md_busy) begin
      mdc_d = mdc_q - MDW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_q <= '0;
    end else begin
      mdc_q <= mdc_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{d_md_start, d_md_div, d_md_use};
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: absolute-time availability model checked every cycle,
// plus directed scenarios with hand-computed stall expectations.
module tb_hazard_scoreboard;
  localparam int NREG    = 32;
  localparam int TNEW_W  = 2;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef HAZARD_MDU_STALL_EN
  localparam logic MDU_EN = 1'b1;
`else
  localparam logic MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [1:0] d_tuse_rs = '1, d_tuse_rt = '1, d_tnew = '0;
  logic       d_wr = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
  logic       stall, stall_rs, stall_rt, stall_md, md_busy;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(
    .NREG(NREG), .TNEW_W(TNEW_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr(d_wr), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt),
    .stall_md(stall_md), .md_busy(md_busy)
  );

  always #10 clk = ~clk;

  // Model: each register's result becomes available at an absolute edge count.
  int E = 0;
  int avail [NREG];
  int md_free = 0;

  function automatic int rem(input int r);
    int a;
    a = avail[r] - E;
    return (a > 0) ? a : 0;
  endfunction

  function automatic logic m_busy();
    return MDU_EN && ((md_free - E) > 0);
  endfunction
  function automatic logic m_rs();
    return d_valid && (d_rs != 0) && (rem(int'(d_rs)) > int'(d_tuse_rs));
  endfunction
  function automatic logic m_rt();
    return d_valid && (d_rt != 0) && (rem(int'(d_rt)) > int'(d_tuse_rt));
  endfunction
  function automatic logic m_md();
    return d_valid && (d_md_use || d_md_start) && m_busy();
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREG; r++) avail[r] = E;
    md_free = E;
  endtask

  initial begin
    logic iss;
    for (int r = 0; r < NREG; r++) avail[r] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_clear();
      end else begin
        iss = d_valid && !(m_rs() || m_rt() || m_md());
        E = E + 1;
        if (iss && d_wr && (d_a3 != 0)) avail[d_a3] = E + int'(d_tnew);
        if (iss && d_md_start && MDU_EN) md_free = E + (d_md_div ? DIV_LAT : MUL_LAT);
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    m_clear();
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    chk("m_stall_rs", stall_rs, m_rs());
    chk("m_stall_rt", stall_rt, m_rt());
    chk("m_stall_md", stall_md, m_md());
    chk("m_md_busy", md_busy, m_busy());
    chk("m_stall", stall, m_rs() || m_rt() || m_md());
  end

  task automatic cyc(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                     input logic [4:0] rt, input logic [1:0] trt, input logic wr,
                     input logic [4:0] a3, input logic [1:0] tn,
                     input logic ms, input logic md, input logic mu);
    @(negedge clk);
    d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_wr = wr; d_a3 = a3; d_tnew = tn; d_md_start = ms; d_md_div = md; d_md_use = mu;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state with a reader presented
    cyc(1'b1, 5'd1, 2'd0, 5'd2, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #3 chk("rst_stall", stall, 1'b0);
    chk("rst_busy", md_busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    idle();

    // Load-use: r8 tnew=2, reader tuse_rs=0 stalls 2 cycles
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("lu_c1", stall, 1'b1);
    chk("lu_c1_rs", stall_rs, 1'b1);
    cyc(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("lu_c2", stall, 1'b1);
    cyc(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("lu_c3", stall, 1'b0);
    idle();

    // cal-then-ALU: r9 tnew=1, reader rt tuse=1 never stalls
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    #3 chk("cal_c0", stall, 1'b0);
    cyc(1'b1, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("cal_c1", stall, 1'b0);
    idle();

    // Register 0 is never tracked
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("r0", stall, 1'b0);
    idle();

    // Unused operand (tuse all-ones), rt stall, and d_valid=0 masking
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd7, 2'd3, 5'd7, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("unused_rs", stall_rs, 1'b0);
    chk("rt_stall", stall_rt, 1'b1);
    cyc(1'b0, 5'd7, 2'd0, 5'd7, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("novalid", stall, 1'b0);
    repeat (3) idle();

    // Divide then multiply occupancy
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DIV_LAT; i++) begin
      cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      #3 chk("div_md", stall_md, MDU_EN);
      chk("div_busy", md_busy, MDU_EN);
    end
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #3 chk("div_end_md", stall_md, 1'b0);
    chk("div_end_busy", md_busy, 1'b0);
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT; i++) begin
      cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      #3 chk("mul_md", stall_md, MDU_EN);
    end
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #3 chk("mul_end_md", stall_md, 1'b0);
    idle();

    // Async reset mid-countdown: cnt[5]=2 and mdc=7
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #3 chk("pre_rst_stall", stall, 1'b1);
    chk("pre_rst_busy", md_busy, MDU_EN);
    #1 rst_n = 1'b0;
    #2 chk("arst_stall", stall, 1'b0);
    chk("arst_rs", stall_rs, 1'b0);
    chk("arst_md", stall_md, 1'b0);
    chk("arst_busy", md_busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    #3 chk("post_rst_stall", stall, 1'b0);
    idle();

    // Overwrite: r3 tnew=2 then tnew=1 -> one stall cycle
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("ow_c1", stall, 1'b1);
    cyc(1'b1, 5'd3, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #3 chk("ow_c2", stall, 1'b0);
    repeat (3) idle();

    @(negedge clk);
    #5 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL provide parameter NREG, default 32, meaning the number of architectural registers tracked; register 0 is never tracked.
REQ-002 The block SHALL provide parameter TNEW_W, default 2, meaning the width of Tnew/Tuse values and per-register countdowns.
REQ-003 The block SHALL provide parameter MUL_LAT, default 5, meaning the HI/LO busy cycles loaded for a multiply.
REQ-004 The block SHALL provide parameter DIV_LAT, default 10, meaning the HI/LO busy cycles loaded for a divide.
REQ-005 The block SHALL have clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have reset, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have d_valid, input, 1, meaning a real (non-bubble) instruction is held in D.
REQ-008 The block SHALL have d_rs and d_rt, input, log2(NREG) each, meaning the D source register indices.
REQ-009 The block SHALL have d_tuse_rs and d_tuse_rt, input, TNEW_W each, meaning the operand-use distance; all-ones means unused.
REQ-010 The block SHALL have d_wr, input, 1, and d_a3, input, log2(NREG), meaning the D instruction writes register d_a3.
REQ-011 The block SHALL have d_tnew, input, TNEW_W, meaning cycles after entering E until the result is forwardable.
REQ-012 The block SHALL have d_md_start, input, 1, and d_md_div, input, 1, meaning D is mult/div (div when d_md_div=1).
REQ-013 The block SHALL have d_md_use, input, 1, meaning D reads or writes HI/LO (mfhi/mflo/mthi/mtlo).
REQ-014 The block SHALL have outputs stall, stall_rs, stall_rt, stall_md, each 1 bit, and md_busy, 1 bit, meaning the HI/LO unit is occupied.

Function
REQ-015 The block SHALL hold a countdown cnt[r] of TNEW_W bits for each register r in 1..NREG-1.
REQ-016 Issue SHALL be defined as d_valid=1 and stall=0 in the same cycle.
REQ-017 Each cycle, every nonzero cnt[r] SHALL decrement by 1, saturating at 0.
REQ-018 On issue with d_wr=1 and d_a3!=0, cnt[d_a3] SHALL load d_tnew at the next edge; this overrides the decrement for that entry.
REQ-019 stall_rs SHALL equal d_valid and d_rs!=0 and cnt[d_rs] > d_tuse_rs; stall_rt SHALL be the same using d_rt and d_tuse_rt.
REQ-020 The block SHALL hold a busy counter mdc, clog2(max(MUL_LAT,DIV_LAT)+1) bits; md_busy SHALL equal (mdc!=0).
REQ-021 On issue with d_md_start=1, mdc SHALL load DIV_LAT if d_md_div=1, else MUL_LAT; otherwise a nonzero mdc SHALL decrement by 1.
REQ-022 stall_md SHALL equal d_valid and (d_md_use or d_md_start) and md_busy.
REQ-023 stall SHALL equal stall_rs or stall_rt or stall_md; all stall outputs SHALL be combinational from the current state and D inputs.
REQ-024 When d_valid=0, all stall outputs SHALL be 0 and no entry SHALL be loaded; countdowns SHALL continue.
REQ-025 d_tnew=0 SHALL load 0, meaning the result is forwardable immediately and no stall occurs.

Reset
REQ-026 Asserting reset low SHALL clear every cnt[r] and mdc to 0 immediately, with no dependence on clk; this applies mid-countdown too.
REQ-027 While reset is low, stall, stall_rs, stall_rt, stall_md and md_busy SHALL all be 0.

Configuration
REQ-028 With macro HAZARD_MDU_STALL_EN defined, the block SHALL implement mdc, md_busy and stall_md as specified.
REQ-029 With HAZARD_MDU_STALL_EN undefined, mdc SHALL NOT exist, and md_busy and stall_md SHALL be tied to 0; d_md_* SHALL be ignored.

Verification
REQ-030 Load-use case: issue d_wr=1, d_a3=8, d_tnew=2, then hold D with d_rs=8, d_tuse_rs=0 -> stall=1 for 2 cycles, then 0.
REQ-031 cal-then-ALU case: d_tnew=1 to register 9, then D reads rt=9 with d_tuse_rt=1 -> stall=0 for the whole sequence.
REQ-032 Register-0 case: issue d_a3=0, d_tnew=2, then D has d_rs=0 -> stall=0 and no entry loaded.
REQ-033 Divide case: issue d_md_start=1, d_md_div=1 (DIV_LAT=10), then d_md_use=1 -> stall_md=1 for exactly 10 cycles, md_busy falls together with stall_md.
REQ-034 Reset case: pull reset low asynchronously while cnt[5]=2 and mdc=7 -> all outputs 0 before the next edge; after release, a reader of r5 does not stall.
REQ-035 Overwrite case: issue r3 with d_tnew=2, then issue r3 with d_tnew=1 the next cycle -> cnt[3]=1, and a d_tuse_rs=0 reader stalls for exactly 1 cycle.
